// File: rtl/pe_conv1d_driver.sv
// pe_conv1d_driver: feeds weights/features from a buffer into a 3-tap MAC PE and queues its results in a FIFO
module pe_conv1d_driver #(
  parameter int DATA_BITS     = 16,
  parameter int INTERNAL_BITS = 32,
  parameter int ADDR_BITS     = 10,
  parameter int LEN_BITS      = 10,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_BITS-1:0]      len,
  input  logic [ADDR_BITS-1:0]     w_base,
  input  logic [ADDR_BITS-1:0]     if_base,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd,
  output logic [ADDR_BITS-1:0]     mem_addr,
  input  logic [DATA_BITS-1:0]     mem_rdata,
  output logic                     pe_w_w,
  output logic                     pe_if_w,
  output logic [DATA_BITS-1:0]     pe_w_in,
  output logic [DATA_BITS-1:0]     pe_if_in,
  input  logic [INTERNAL_BITS-1:0] pe_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INTERNAL_BITS-1:0] out_data,
  output logic [LEN_BITS-1:0]      out_index
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, DONE} state_t;
  state_t                   r_state;
  logic [LEN_BITS-1:0]      r_len, r_fcnt, r_wr_idx, r_cap_idx;
  logic [ADDR_BITS-1:0]     r_w_base, r_if_base, r_mem_addr;
  logic [1:0]               r_wcnt;
  logic                     r_mem_rd, r_rd_w, r_pe_w_w, r_pe_if_w, r_cap, r_busy, r_done;
  logic [CW-1:0]            r_cnt, r_pend;
  logic [PW-1:0]            r_wp, r_rp;
  logic [INTERNAL_BITS-1:0] r_fd [FIFO_DEPTH];
  logic [LEN_BITS-1:0]      r_fi [FIFO_DEPTH];
  logic                     w_pop, w_push, w_first2, w_credit, w_issue, w_inc;
  logic [CW-1:0]            w_cnt_n, w_pend_n;
  assign w_pop    = out_valid & out_ready;
  assign w_push   = r_cap;
  assign w_first2 = r_fcnt < LEN_BITS'(2);
  // credit counts this cycle's pop so a full-rate stream never stalls
  assign w_credit = (r_cnt - CW'(w_pop) + r_pend) < CW'(FIFO_DEPTH);
  assign w_issue  = (r_state == FEED) && (w_first2 || w_credit);
  assign w_inc    = w_issue && !w_first2;
  assign w_cnt_n  = r_cnt + CW'(w_push) - CW'(w_pop);
  assign w_pend_n = r_pend + CW'(w_inc) - CW'(w_push);
  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_rd    = r_mem_rd;
  assign mem_addr  = r_mem_addr;
  assign pe_w_w    = r_pe_w_w;
  assign pe_if_w   = r_pe_if_w;
  assign pe_w_in   = r_pe_w_w ? mem_rdata : '0;
  assign pe_if_in  = r_pe_if_w ? mem_rdata : '0;
  assign out_valid = r_cnt != '0;
  assign out_data  = out_valid ? r_fd[r_rp] : '0;
  assign out_index = out_valid ? r_fi[r_rp] : '0;
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fd[r_wp] <= pe_result;
      r_fi[r_wp] <= r_cap_idx;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_fcnt     <= '0;
      r_wr_idx   <= '0;
      r_cap_idx  <= '0;
      r_w_base   <= '0;
      r_if_base  <= '0;
      r_mem_addr <= '0;
      r_wcnt     <= '0;
      r_mem_rd   <= 1'b0;
      r_rd_w     <= 1'b0;
      r_pe_w_w   <= 1'b0;
      r_pe_if_w  <= 1'b0;
      r_cap      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_pend     <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
    end else begin
      r_pe_w_w  <= r_mem_rd & r_rd_w;
      r_pe_if_w <= r_mem_rd & ~r_rd_w;
      r_wr_idx  <= r_pe_if_w ? r_wr_idx + LEN_BITS'(1) : r_wr_idx;
      r_cap     <= r_pe_if_w && (r_wr_idx >= LEN_BITS'(2));
      r_cap_idx <= r_wr_idx - LEN_BITS'(2);
      r_cnt     <= w_cnt_n;
      r_pend    <= w_pend_n;
      r_wp      <= w_push ? r_wp + PW'(1) : r_wp;
      r_rp      <= w_pop ? r_rp + PW'(1) : r_rp;
      r_mem_rd  <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_len     <= len;
          r_w_base  <= w_base;
          r_if_base <= if_base;
          r_fcnt    <= LEN_BITS'(1);
          r_wr_idx  <= '0;
          if (len < LEN_BITS'(3)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= LOAD_W;
            r_busy     <= 1'b1;
            r_mem_rd   <= 1'b1;
            r_rd_w     <= 1'b1;
            r_mem_addr <= w_base;
            r_wcnt     <= 2'd1;
          end
        end
        LOAD_W: begin
          r_mem_rd <= 1'b1;
          if (r_wcnt != 2'd3) begin
            r_mem_addr <= r_w_base + ADDR_BITS'(r_wcnt);
            r_wcnt     <= r_wcnt + 2'd1;
          end else begin
            r_state    <= FEED;
            r_rd_w     <= 1'b0;
            r_mem_addr <= r_if_base;
          end
        end
        FEED: if (w_issue) begin
          r_mem_rd   <= 1'b1;
          r_mem_addr <= r_if_base + ADDR_BITS'(r_fcnt);
          r_fcnt     <= r_fcnt + LEN_BITS'(1);
          if (r_fcnt == r_len - LEN_BITS'(1)) r_state <= DRAIN;
        end
        DRAIN: if (w_pend_n == '0 && w_cnt_n == '0) begin
          r_state <= DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_conv1d_driver.sv
// tb_pe_conv1d_driver: directed jobs against a buffer model and a shifting 3-tap PE model
module tb_pe_conv1d_driver;
  logic        clk = 0, rst = 1, start = 0, out_ready = 1;
  logic [9:0]  len = 0, w_base = 0, if_base = 0;
  logic        busy, done, mem_rd, pe_w_w, pe_if_w, out_valid;
  logic [9:0]  mem_addr, out_index;
  logic [15:0] mem_rdata, pe_w_in, pe_if_in;
  logic [31:0] pe_result, out_data;
  always #5 clk = ~clk;
  pe_conv1d_driver dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .w_base(w_base), .if_base(if_base),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pe_w_w(pe_w_w), .pe_if_w(pe_if_w), .pe_w_in(pe_w_in), .pe_if_in(pe_if_in),
    .pe_result(pe_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index)
  );
  logic [15:0] mem [1024];
  always @(posedge clk) mem_rdata <= mem[mem_addr];
  // PE: oldest write sits in slot 0, so slot k pairs weight k with feature j+k
  logic signed [31:0] pw [3];
  logic signed [31:0] pf [3];
  always @(posedge clk) begin
    if (pe_w_w) begin
      pw[0] <= pw[1];
      pw[1] <= pw[2];
      pw[2] <= 32'(signed'(pe_w_in));
    end
    if (pe_if_w) begin
      pf[0] <= pf[1];
      pf[1] <= pf[2];
      pf[2] <= 32'(signed'(pe_if_in));
    end
  end
  assign pe_result = pw[0] * pf[0] + pw[1] * pf[1] + pw[2] * pf[2];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_rd = 0, n_ww = 0, n_fw = 0, n_done = 0, n_busy = 0, done_cyc = 0, hold_bad = 0;
  logic [9:0]  aq [$];
  logic [31:0] dq [$];
  logic [9:0]  iq [$];
  int          pq [$];
  logic [31:0] prev_d;
  logic [9:0]  prev_i;
  logic        prev_stall = 0;
  always @(negedge clk) begin
    if (mem_rd) begin
      n_rd++;
      aq.push_back(mem_addr);
    end
    if (pe_w_w) n_ww++;
    if (pe_if_w) n_fw++;
    if (busy) n_busy++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      dq.push_back(out_data);
      iq.push_back(out_index);
      pq.push_back(cyc);
    end
    if (prev_stall && out_valid && (out_data !== prev_d || out_index !== prev_i)) hold_bad++;
    prev_stall = out_valid && !out_ready;
    prev_d = out_data;
    prev_i = out_index;
  end
  int n_chk = 0, n_err = 0;
  int b_rd, b_ww, b_fw, b_done, b_busy, b_q, b_a, s_cyc;
  logic [31:0] exp_q [$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic snap();
    b_rd = n_rd; b_ww = n_ww; b_fw = n_fw; b_done = n_done; b_busy = n_busy;
    b_q = dq.size(); b_a = aq.size();
  endtask
  task automatic job(input int l, input int wb, input int ib);
    start = 1; len = 10'(l); w_base = 10'(wb); if_base = 10'(ib);
    s_cyc = cyc;
    tick(1);
    start = 0;
  endtask
  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == b_done && k < budget) begin
      tick(1);
      k++;
    end
    check("done_seen", 64'(n_done - b_done), 1);
    tick(1);
  endtask
  task automatic cmp_outs();
    check("n_out", 64'(dq.size() - b_q), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++)
      if (b_q + j < dq.size()) begin
        check($sformatf("data%0d", j), 64'(dq[b_q + j]), 64'(exp_q[j]));
        check($sformatf("index%0d", j), 64'(iq[b_q + j]), 64'(j));
      end
  endtask
  initial begin
    logic [9:0] exp_a [7];
    int r15;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 3; i++) mem[100 + i] = 16'(i + 1);
    for (int i = 0; i < 5; i++) mem[200 + i] = 16'(i + 1);
    mem[300] = 16'hFFFF; mem[301] = 16'h0000; mem[302] = 16'h0001;
    mem[310] = 16'h7FFF; mem[311] = 16'h8000; mem[312] = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      mem[320 + i] = 16'h8000;
      mem[330 + i] = 16'h8000;
    end
    for (int i = 0; i < 3; i++) mem[400 + i] = 16'(i + 1);
    for (int i = 0; i < 10; i++) mem[410 + i] = 16'(i + 1);
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_strobes", {pe_w_w, pe_if_w}, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    rst = 0;
    tick(2);
    // nominal job, with a start pulse while busy that must be ignored
    snap();
    job(5, 100, 200);
    tick(2);
    start = 1; len = 3; w_base = 0; if_base = 0;
    tick(1);
    start = 0;
    wait_done(100);
    exp_q = '{32'd14, 32'd20, 32'd26};
    cmp_outs();
    check("first_valid_lat", 64'(pq[b_q] - s_cyc), 9);
    check("done_after_pop", 64'(done_cyc - pq[b_q + 2]), 1);
    check("n_w_strobe", 64'(n_ww - b_ww), 3);
    check("n_if_strobe", 64'(n_fw - b_fw), 5);
    check("n_done_pulses", 64'(n_done - b_done), 1);
    // signed extremes
    snap();
    job(3, 300, 310);
    wait_done(100);
    exp_q = '{32'hFFFF8006};
    cmp_outs();
    snap();
    job(3, 320, 330);
    wait_done(100);
    exp_q = '{32'hC0000000};
    cmp_outs();
    // backpressure: reads must stop once fifo plus in-flight reaches depth
    out_ready = 0;
    snap();
    job(10, 400, 410);
    tick(14);
    r15 = n_rd;
    tick(5);
    check("bp_reads", 64'(n_rd - b_rd), 9);
    check("bp_reads_stopped", 64'(n_rd), 64'(r15));
    check("bp_valid", out_valid, 1);
    check("bp_head_data", out_data, 14);
    check("bp_head_index", out_index, 0);
    out_ready = 1;
    wait_done(200);
    exp_q = '{32'd14, 32'd20, 32'd26, 32'd32, 32'd38, 32'd44, 32'd50, 32'd56};
    cmp_outs();
    check("bp_hold", 64'(hold_bad), 0);
    // short jobs
    snap();
    job(2, 100, 200);
    wait_done(20);
    check("len2_done_lat", 64'(done_cyc - s_cyc), 1);
    check("len2_reads", 64'(n_rd - b_rd), 0);
    check("len2_strobes", 64'(n_ww - b_ww + n_fw - b_fw), 0);
    check("len2_busy", 64'(n_busy - b_busy), 0);
    snap();
    job(0, 100, 200);
    wait_done(20);
    check("len0_done_lat", 64'(done_cyc - s_cyc), 1);
    check("len0_reads", 64'(n_rd - b_rd), 0);
    // address wrap; feature and weight regions overlap on purpose
    mem[1022] = 16'd5; mem[1023] = 16'd2; mem[0] = 16'd3; mem[1] = 16'd4;
    snap();
    job(4, 1023, 1022);
    wait_done(100);
    exp_a = '{10'd1023, 10'd0, 10'd1, 10'd1022, 10'd1023, 10'd0, 10'd1};
    check("wrap_n_reads", 64'(aq.size() - b_a), 7);
    for (int k = 0; k < 7; k++)
      if (b_a + k < aq.size()) check($sformatf("wrap_addr%0d", k), 64'(aq[b_a + k]), 64'(exp_a[k]));
    exp_q = '{32'd28, 32'd29};
    cmp_outs();
    // reset mid-feed with two entries queued
    for (int i = 0; i < 3; i++) mem[100 + i] = 16'(i + 1);
    out_ready = 0;
    snap();
    job(10, 400, 410);
    tick(9);
    check("pre_rst_valid", out_valid, 1);
    rst = 1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_index", out_index, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_rd", mem_rd, 0);
    tick(2);
    rst = 0;
    tick(1);
    out_ready = 1;
    snap();
    job(5, 100, 200);
    wait_done(100);
    exp_q = '{32'd14, 32'd20, 32'd26};
    cmp_outs();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pe_conv1d_driver.md
Name: pe_conv1d_driver

Overview:
Sequencer that drives a 3-tap MAC processing element from the other side of its write-strobe interface.
- Reads 3 weights and a stream of input features from a shared single-port buffer.
- Pushes them into the PE with weight/feature write strobes.
- Samples the PE's combinational 3-tap result after each valid window and queues it in an output FIFO with valid/ready handshake.
- Sits between the buffer/controller and one PE in the CNN datapath.

Parameters:
DATA_BITS, 16, width of weights/features (signed)
INTERNAL_BITS, 32, width of PE result (signed)
ADDR_BITS, 10, buffer address width
LEN_BITS, 10, width of feature-count input
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle job start; ignored while busy
len  in  LEN_BITS  number of input features in job
w_base  in  ADDR_BITS  address of weight 0 (weights at w_base, +1, +2)
if_base  in  ADDR_BITS  address of feature 0
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse at job completion
mem_rd  out  1  buffer read enable
mem_addr  out  ADDR_BITS  buffer read address
mem_rdata  in  DATA_BITS  read data, valid exactly 1 cycle after mem_rd
pe_w_w  out  1  PE weight write strobe
pe_if_w  out  1  PE feature write strobe
pe_w_in  out  DATA_BITS  PE weight data
pe_if_in  out  DATA_BITS  PE feature data
pe_result  in  INTERNAL_BITS  PE combinational result (signed)
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accepts head
out_data  out  INTERNAL_BITS  result, pe_result unmodified
out_index  out  LEN_BITS  output index j of head entry

Behaviour:
- Reset: all outputs 0, FSM=IDLE, FIFO empty, all counters 0. Reset mid-job aborts immediately; no done pulse; PE contents are don't-care (the next job fully rewrites them).
- Function: out[j] = W[0]*IF[j] + W[1]*IF[j+1] + W[2]*IF[j+2], for j = 0..len-3, delivered in order. The PE shifts, so the oldest write pairs with the oldest.
- FSM: IDLE -> LOAD_W -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE: on start, latch len/w_base/if_base.
  - len<3: go directly to DONE; no mem_rd, no PE writes.
  - Otherwise go to LOAD_W.
- LOAD_W: 3 consecutive cycles with mem_rd=1, addresses w_base+0, +1, +2. Then FEED.
- Data forwarding: pe_w_w = mem_rd delayed 1 cycle (weight read); pe_w_in = mem_rdata. Same for pe_if_w/pe_if_in on feature reads. The strobe never coincides with the wrong data.
- FEED: issue feature read i at if_base+i, i = 0..len-1, at most 1 per cycle.
  - Reads i=0,1 are issued unconditionally.
  - Read i>=2 is issued only if fifo_count + pending < FIFO_DEPTH. pending = issued result-producing reads not yet pushed, 0..2.
  - After the last read is issued, go to DRAIN.
- Capture: for feature write i>=2 (strobe in cycle c), pe_result is sampled at the end of cycle c+1 and pushed with index i-2. Capture uses the end-of-cycle value, so it is unaffected by the simultaneous next feature write.
- Nominal timing:
  - start sampled at the end of cycle 0.
  - mem_rd for weights in cycles 1-3.
  - Feature reads from cycle 4.
  - First out_valid in cycle 9.
  - Throughput: 1 output/cycle when out_ready stays high.
- DRAIN: wait until pending=0 and FIFO empty, then DONE. DONE lasts 1 cycle with done=1; busy is 0 in DONE.
- FIFO: push and pop in the same cycle are allowed, with count unchanged. Overflow cannot occur by the credit rule. out_data/out_index hold stable while out_valid && !out_ready.
- Address arithmetic wraps modulo 2^ADDR_BITS.
- len=0 counts as len<3. Max len = 2^LEN_BITS-1.
- start asserted during DONE is ignored.

Test Plan:
- Weights [1,2,3], features [1,2,3,4,5], len=5, out_ready=1 -> out (0,14),(1,20),(2,26); first out_valid 9 cycles after the start cycle; done 1 cycle after the last pop.
- Signed: weights [-1,0,1], features [32767,-32768,5] -> single output -32762; weights [-32768,-32768,-32768], features all -32768 -> 3221225472 as 32-bit 0xC0000000.
- Backpressure: len=10, out_ready low for 20 cycles then high -> mem_rd stops with FIFO at 4 plus pending 0; all 8 outputs correct and in order; no loss or duplication.
- len=2 (and len=0) -> no mem_rd, no PE strobes, done pulse the cycle after start; start while busy ignored.
- Wrap: w_base=1023, if_base=1022 -> read addresses 1023,0,1 then 1022,1023,0,...
- rst asserted mid-FEED with 2 FIFO entries -> outputs immediately 0, FIFO empty; a new job after reset produces correct results.
